// File: rtl/decode_stage_register.sv
// Decode->execute pipeline register with valid/ready handshake, flush, and saturating stall counter.
// Latency 1 cycle. Backpressure: READY_OUT = !VALID_OUT || READY_IN, or registered skid-empty when DECODE_STAGE_REG_SKID_EN is defined.
module decode_stage_register #(
    parameter int AR_W  = 3,
    parameter int BR_W  = 3,
    parameter int ALU_W = 4,
    parameter int IN_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             VALID_IN,
    output logic             READY_OUT,
    input  logic [AR_W-1:0]  AR_IN,
    input  logic [BR_W-1:0]  BR_IN,
    input  logic [ALU_W-1:0] ALU_IN,
    input  logic [IN_W-1:0]  input_IN,
    input  logic             wren_IN,
    input  logic             FLUSH_IN,
    output logic             VALID_OUT,
    input  logic             READY_IN,
    output logic [AR_W-1:0]  AR_OUT,
    output logic [BR_W-1:0]  BR_OUT,
    output logic [ALU_W-1:0] ALU_OUT,
    output logic [IN_W-1:0]  input_OUT,
    output logic             wren_OUT,
    input  logic             CLR_CNT_IN,
    output logic [CNT_W-1:0] STALL_CNT_OUT
);

    typedef struct packed {
        logic [AR_W-1:0]  ar;
        logic [BR_W-1:0]  br;
        logic [ALU_W-1:0] alu;
        logic [IN_W-1:0]  sel;
        logic             wren;
    } ctrl_t;

    ctrl_t            in_word;
    ctrl_t            main_q;
    logic             main_vld;
    logic             accept;
    logic             consume;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    assign in_word = {AR_IN, BR_IN, ALU_IN, input_IN, wren_IN};
    assign accept  = VALID_IN && READY_OUT;
    assign consume = main_vld && READY_IN;
    assign stall   = main_vld && !READY_IN;

`ifdef DECODE_STAGE_REG_SKID_EN
    ctrl_t skid_q;
    logic  skid_vld;

    // Ready depends only on skid occupancy, so no READY_IN->READY_OUT path exists.
    assign READY_OUT = !skid_vld;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            main_q   <= '0;
            main_vld <= 1'b0;
            skid_q   <= '0;
            skid_vld <= 1'b0;
        end else if (FLUSH_IN) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld || consume) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else if (accept) begin
                main_q   <= in_word;
                main_vld <= 1'b1;
            end else begin
                main_vld <= 1'b0;
            end
        end else if (accept) begin
            skid_q   <= in_word;
            skid_vld <= 1'b1;
        end
    end
`else
    assign READY_OUT = !main_vld || READY_IN;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            main_q   <= '0;
            main_vld <= 1'b0;
        end else if (FLUSH_IN) begin
            main_vld <= 1'b0;
        end else if (accept) begin
            main_q   <= in_word;
            main_vld <= 1'b1;
        end else if (consume) begin
            main_vld <= 1'b0;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cnt <= '0;
        end else if (CLR_CNT_IN) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign VALID_OUT     = main_vld;
    assign AR_OUT        = main_q.ar;
    assign BR_OUT        = main_q.br;
    assign ALU_OUT       = main_q.alu;
    assign input_OUT     = main_q.sel;
    assign wren_OUT      = main_q.wren & main_vld;
    assign STALL_CNT_OUT = stall_cnt;

endmodule

// File: doc/decode_stage_register.md
# decode_stage_register

Parametrised pipeline register between the decode unit and the execute stage. It carries the decoded control word (A-register select, B-register select, ALU operation, input-mux select, write enable) under a valid/ready handshake, so the stage can stall. It also supports a synchronous flush that inserts bubbles and a saturating stall-cycle counter. It is the next generation of the single-word, always-advancing decode register.

## Interface
- AR_W, default 3, width of the A-register select field
- BR_W, default 3, width of the B-register select field
- ALU_W, default 4, width of the ALU operation field
- IN_W, default 2, width of the input-mux select field
- CNT_W, default 16, width of the stall counter
- CLK  input  1  clock; all state changes on its rising edge
- RST_N  input  1  asynchronous, active-low reset
- VALID_IN  input  1  upstream presents a decoded word
- READY_OUT  output  1  block can accept a word this cycle
- AR_IN / BR_IN / ALU_IN / input_IN  input  AR_W / BR_W / ALU_W / IN_W  control fields
- wren_IN  input  1  write-enable field
- FLUSH_IN  input  1  synchronous flush; discards every held word
- VALID_OUT  output  1  output word is valid
- READY_IN  input  1  downstream accepts the output word this cycle
- AR_OUT / BR_OUT / ALU_OUT / input_OUT  output  field widths  registered control fields
- wren_OUT  output  1  registered write enable, gated by VALID_OUT
- CLR_CNT_IN  input  1  synchronous clear of the stall counter
- STALL_CNT_OUT  output  CNT_W  count of stalled cycles

## Operation
- A beat is accepted when VALID_IN && READY_OUT at a rising CLK edge.
- A beat is consumed when VALID_OUT && READY_IN at a rising CLK edge.
- The main entry holds the word being presented downstream. The field outputs come directly from the main-entry registers.
- wren_OUT = main wren & VALID_OUT, so a bubble never writes. The other fields keep their last value while VALID_OUT=0.
- If the main entry is empty or is being consumed, an accepted beat loads the main entry.
- Beats are delivered in order. None are dropped or duplicated, except on flush.
- FLUSH_IN has the highest priority:
  - all entries become invalid on the next edge;
  - any beat accepted in the same cycle is discarded;
  - field registers keep their data.
- Stall counter:
  - increments each cycle VALID_OUT && !READY_IN;
  - saturates at 2^CNT_W−1;
  - CLR_CNT_IN and RST_N set it to 0. When CLR_CNT_IN and a stall occur in the same cycle, clear wins and the result is 0.
- Reset state:
  - VALID_OUT=0, wren_OUT=0;
  - all field outputs 0;
  - STALL_CNT_OUT=0, skid entry empty;
  - READY_OUT=1 once RST_N is released.
- Asserting RST_N mid-transfer loses every held beat immediately, with no clock edge required.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on the outputs after edge N.
- Throughput is one beat per cycle while READY_IN=1.
- A stall holds the outputs stable for as long as VALID_OUT=1 and READY_IN=0.
- Once VALID_OUT is 1, it stays 1 until the beat is consumed or the block is flushed.
- Without the skid option, READY_OUT = !VALID_OUT || READY_IN. This is a combinational path from READY_IN.
- With the skid option, READY_OUT is a registered signal equal to "skid entry empty".

## Configuration
- Macro: DECODE_STAGE_REG_SKID_EN.
- When defined, a second skid entry is added:
  - A beat accepted while the main entry is full and not being consumed goes into the skid entry. READY_OUT then drops on the next cycle.
  - When the main entry is consumed, the skid word moves to the main entry and READY_OUT rises on the next cycle.
  - Full throughput is kept, and there is no combinational READY_IN→READY_OUT path.
  - Flush clears both entries.
- When undefined: single entry only, using the combinational READY_OUT given under Timing.

## Test plan
- Reset: hold RST_N=0 mid-stream -> VALID_OUT=0, wren_OUT=0, all fields 0, STALL_CNT_OUT=0; after release READY_OUT=1.
- Streaming: READY_IN=1, send 8 back-to-back words (ALU_IN=0..7, wren_IN=1) -> outputs are ALU_OUT=0..7 on consecutive cycles, each 1 cycle after acceptance, VALID_OUT continuous.
- Stall: word A (AR_IN=5) accepted, then READY_IN=0 for 3 cycles while word B is offered:
  - outputs hold A for all 3 cycles;
  - STALL_CNT_OUT=3;
  - skid build: B accepted, then READY_OUT=0; B appears after A is consumed;
  - non-skid build: B is not accepted until READY_IN rises.
- Flush: two words held (skid build) or one word held, FLUSH_IN=1 together with VALID_IN=1 -> next cycle VALID_OUT=0, wren_OUT=0, no held or incoming word ever appears, READY_OUT=1.
- Counter: CNT_W=4, stall for 20 cycles -> STALL_CNT_OUT saturates at 15; CLR_CNT_IN asserted during a stall cycle -> 0 on the next cycle.
